// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encodings and constants for the core controller
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  localparam logic [7:0] CYCLE_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CYCLE_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/step_edge.sv
// rtl/step_edge.sv - rising-edge detector for the single-step request
module step_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic prev;
  logic armed;

  // armed stays low until the input has been seen low once, so a level
  // already high when reset releases cannot masquerade as a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= in;
      armed <= armed | ~in;
    end
  end

  assign pulse = in & ~prev & armed;

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - program loader and run/step/halt sequencer for a small core
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              run,
  input  logic              step,
  input  logic              core_halted,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_en,
  output logic              core_rst,
  output logic              step_done,
  output logic [2:0]        state,
  output logic [7:0]        cycle_count
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] wr_cnt;
  logic              step_pulse;
  logic              accept;
  logic              at_full;
  logic              load_exit;
  logic              halt_exit;
  logic              enter_load;

  step_edge u_step_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (step),
    .pulse (step_pulse)
  );

  assign load_ready = (state_q == ST_LOAD);
  assign accept     = load_valid && load_ready;
  assign at_full    = (wr_cnt == {ADDR_W{1'b1}});
  assign core_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  assign state      = state_q;

  always_comb begin
    state_d   = state_q;
    load_exit = 1'b0;
    halt_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_en)         state_d = ST_LOAD;
        else if (run)        state_d = ST_RUN;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_LOAD: begin
        if (!load_en || (accept && at_full)) begin
          state_d   = ST_IDLE;
          load_exit = 1'b1;
        end
      end
      ST_RUN: begin
        if (core_halted) state_d = ST_HALT;
        else if (!run)   state_d = ST_IDLE;
      end
      ST_STEP: begin
        state_d = core_halted ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (load_en) begin
          state_d = ST_LOAD;
        end else if (!run) begin
          state_d   = ST_IDLE;
          halt_exit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // write address saturates at the last slot; the accept there ends LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= wr_cnt;
        mem_wdata <= load_data;
      end
      if (enter_load) begin
        wr_cnt <= '0;
      end else if (accept && !at_full) begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst    <= 1'b0;
      step_done   <= 1'b0;
      cycle_count <= '0;
    end else begin
      core_rst  <= load_exit | halt_exit;
      step_done <= (state_q == ST_STEP);
      if (load_exit || halt_exit) begin
        cycle_count <= '0;
      end else if (core_en) begin
        cycle_count <= sat_inc(cycle_count);
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - directed vector bench for core_ctrl
module tb_core_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic       load_valid;
  logic [6:0] load_data;
  logic       load_ready;
  logic       run;
  logic       step;
  logic       core_halted;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [6:0] mem_wdata;
  logic       core_en;
  logic       core_rst;
  logic       step_done;
  logic [2:0] state;
  logic [7:0] cycle_count;

  int checks   = 0;
  int failures = 0;
  int n_we     = 0;
  int n_rst    = 0;
  int n_en     = 0;
  int n_done   = 0;
  int base_we, base_rst, base_en, base_done;

  core_ctrl #(.ADDR_W(4), .DATA_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .run         (run),
    .step        (step),
    .core_halted (core_halted),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_en     (core_en),
    .core_rst    (core_rst),
    .step_done   (step_done),
    .state       (state),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we)    n_we   = n_we + 1;
    if (core_rst)  n_rst  = n_rst + 1;
    if (core_en)   n_en   = n_en + 1;
    if (step_done) n_done = n_done + 1;
  end

  typedef struct {
    logic       le;
    logic       lv;
    logic [6:0] ld;
    logic       rn;
    logic       st;
    logic       hl;
    logic [2:0] e_state;
    logic       e_ready;
    logic       e_en;
    logic       e_we;
    logic       e_rst;
    logic       e_done;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic step_level);
    rst_n       = 1'b0;
    load_en     = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    run         = 1'b0;
    step        = step_level;
    core_halted = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 7'd5, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 7'd3, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{1'b0, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[10] = '{1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    do_reset(1'b0);
    #1;
    chk("rst_state", state, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_en", core_en, 0);
    chk("rst_we", mem_we, 0);

    // per-cycle vectors: IDLE priority, pause, step edge, step into HALT, halt exit
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      load_en     = vecs[i].le;
      load_valid  = vecs[i].lv;
      load_data   = vecs[i].ld;
      run         = vecs[i].rn;
      step        = vecs[i].st;
      core_halted = vecs[i].hl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_ready", i), load_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_en", i), core_en, vecs[i].e_en);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
      chk($sformatf("v%0d_rst", i), core_rst, vecs[i].e_rst);
      chk($sformatf("v%0d_done", i), step_done, vecs[i].e_done);
      chk($sformatf("v%0d_cnt", i), cycle_count, vecs[i].e_cnt);
    end

    // full 16-word load
    do_reset(1'b0);
    @(negedge clk);
    load_en = 1'b1;
    @(posedge clk);
    #1;
    chk("full_enter", state, 1);
    base_we  = n_we;
    base_rst = n_rst;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 7'(i + 1);
      @(posedge clk);
      #1;
      chk($sformatf("full_we%0d", i), mem_we, 1);
      chk($sformatf("full_addr%0d", i), mem_addr, i);
      chk($sformatf("full_data%0d", i), mem_wdata, i + 1);
    end
    chk("full_state", state, 0);
    @(negedge clk);
    load_en    = 1'b0;
    load_data  = 7'h11;
    chk("full_ready17", load_ready, 0);
    @(posedge clk);
    #1;
    chk("full_we17", mem_we, 0);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("full_writes", n_we - base_we, 16);
    chk("full_rst_pulses", n_rst - base_rst, 1);

    // run 10 cycles then pause
    do_reset(1'b0);
    base_en  = n_en;
    base_rst = n_rst;
    @(negedge clk);
    run = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("run_state", state, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("run_en_cycles", n_en - base_en, 10);
    chk("run_cnt", cycle_count, 10);
    chk("run_no_rst", n_rst - base_rst, 0);

    // short load aborted by load_en falling; also clears the run count
    base_we  = n_we;
    base_rst = n_rst;
    @(negedge clk);
    load_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 7'(8'h20 + i);
      @(posedge clk);
      #1;
      chk($sformatf("part_addr%0d", i), mem_addr, i);
      chk($sformatf("part_data%0d", i), mem_wdata, 32'h20 + i);
    end
    @(negedge clk);
    load_en    = 1'b0;
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("part_state", state, 0);
    chk("part_core_rst", core_rst, 1);
    chk("part_cnt", cycle_count, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("part_writes", n_we - base_we, 3);
    chk("part_rst_pulses", n_rst - base_rst, 1);

    // step held high for 5 cycles
    base_en   = n_en;
    base_done = n_done;
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1;
    chk("step_state", state, 3);
    chk("step_en", core_en, 1);
    @(posedge clk);
    #1;
    chk("step_done", step_done, 1);
    chk("step_back_idle", state, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    step = 1'b0;
    @(posedge clk);
    #1;
    chk("step_en_cycles", n_en - base_en, 1);
    chk("step_done_cycles", n_done - base_done, 1);
    chk("step_cnt", cycle_count, 1);

    // halt during run, step ignored in HALT, run low releases with core_rst
    do_reset(1'b0);
    @(negedge clk);
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    core_halted = 1'b1;
    @(posedge clk);
    #1;
    chk("halt_state", state, 4);
    chk("halt_en", core_en, 0);
    chk("halt_cnt", cycle_count, 3);
    @(negedge clk);
    core_halted = 1'b0;
    step        = 1'b1;
    @(posedge clk);
    #1;
    chk("halt_step_ign", state, 4);
    @(negedge clk);
    run  = 1'b0;
    step = 1'b0;
    @(posedge clk);
    #1;
    chk("halt_exit_state", state, 0);
    chk("halt_exit_rst", core_rst, 1);
    chk("halt_exit_cnt", cycle_count, 0);
    @(posedge clk);
    #1;
    chk("halt_rst_single", core_rst, 0);

    // halt beats run low in the same cycle
    do_reset(1'b0);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run         = 1'b0;
    core_halted = 1'b1;
    @(posedge clk);
    #1;
    chk("prio_halt", state, 4);

    // asynchronous reset in the middle of a load
    do_reset(1'b0);
    @(negedge clk);
    load_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 7'(i + 1);
      @(posedge clk);
    end
    #1;
    chk("arst_pre_addr", mem_addr, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_data", mem_wdata, 0);
    chk("arst_ready", load_ready, 0);
    chk("arst_core_rst", core_rst, 0);
    @(negedge clk);
    load_en = 1'b0;
    rst_n   = 1'b1;
    base_we = n_we;
    repeat (5) @(posedge clk);
    #1;
    chk("arst_no_writes", n_we - base_we, 0);
    chk("arst_idle", state, 0);
    load_valid = 1'b0;

    // step already high across reset release must not fire
    do_reset(1'b1);
    base_en = n_en;
    repeat (4) @(posedge clk);
    #1;
    chk("rstep_idle", state, 0);
    chk("rstep_no_en", n_en - base_en, 0);
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1;
    chk("rstep_rearm", state, 3);
    @(negedge clk);
    step = 1'b0;

    // cycle_count saturation
    do_reset(1'b0);
    @(negedge clk);
    run = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    chk("sat_cnt", cycle_count, 255);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_hold", cycle_count, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program-memory address width (depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 7, program word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port load_en, input, 1, request program-load mode.
REQ-006 SHALL have port load_valid, input, 1, load_data holds a valid word.
REQ-007 SHALL have port load_data, input, DATA_W, program word to store.
REQ-008 SHALL have port load_ready, output, 1, block accepts a word this cycle.
REQ-009 SHALL have port run, input, 1, level request for free-running execution.
REQ-010 SHALL have port step, input, 1, single-step request, rising-edge sensitive.
REQ-011 SHALL have port core_halted, input, 1, core executed HALT.
REQ-012 SHALL have port mem_we, output, 1, program-memory write strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_W, program-memory write address.
REQ-014 SHALL have port mem_wdata, output, DATA_W, program-memory write data.
REQ-015 SHALL have port core_en, output, 1, core clock enable, one instruction per high cycle.
REQ-016 SHALL have port core_rst, output, 1, synchronous one-cycle core/PC reset pulse.
REQ-017 SHALL have port step_done, output, 1, one-cycle pulse after a single step.
REQ-018 SHALL have port state, output, 3, current FSM state code.
REQ-019 SHALL have port cycle_count, output, 8, executed-instruction count since last core_rst.

Function
REQ-020 SHALL implement states IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
REQ-021 In IDLE SHALL pick next state by priority load_en > run > step rising edge; else remain.
REQ-022 On IDLE->LOAD SHALL clear the write-address counter to 0.
REQ-023 load_ready SHALL equal (state==LOAD); nowhere else.
REQ-024 Accept = load_valid && load_ready; SHALL register mem_we=1, mem_addr=counter, mem_wdata=load_data on the next cycle (1-cycle latency), then increment counter.
REQ-025 load_valid outside LOAD SHALL be ignored; mem_we SHALL be 0.
REQ-026 LOAD SHALL exit to IDLE when load_en falls, or on the accept at address 2**ADDR_W-1 (full); counter SHALL NOT wrap.
REQ-027 On every LOAD exit SHALL assert core_rst for exactly one cycle and clear cycle_count.
REQ-028 In RUN SHALL hold core_en=1 each cycle; run low -> IDLE (pause, no core_rst); core_halted -> HALT (core_halted wins over run low).
REQ-029 STEP SHALL last one cycle with core_en=1, then step_done=1 for one cycle; next state IDLE, or HALT if core_halted sampled high in the STEP cycle.
REQ-030 In HALT SHALL hold core_en=0; step ignored; load_en -> LOAD; else run low -> IDLE with one-cycle core_rst.
REQ-031 cycle_count SHALL increment on each core_en cycle, saturating at 255.
REQ-032 step held high SHALL produce only one step; re-arm requires step low for at least one cycle.
REQ-033 core_en SHALL be 0 in IDLE, LOAD, HALT.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, counter=0, cycle_count=0, core_en=0, mem_we=0, mem_addr=0, mem_wdata=0, step_done=0, core_rst=0, step-edge register=0.
REQ-035 Reset during LOAD or RUN SHALL abort with no further mem_we or core_en after deassertion until a new request.
REQ-036 After rst_n rises, an already-high step SHALL NOT trigger a step.

Structure
REQ-037 State encodings and the cycle_count saturation constant SHALL live in shared package core_ctrl_pkg.
REQ-038 Step rising-edge detection SHALL be sub-module step_edge (clk, rst_n, in, pulse).

Verification
REQ-039 Load 16 words 0x01..0x10 back-to-back -> mem_we 16 cycles, addr 0..15, data matches; 17th load_valid not accepted; IDLE; one core_rst pulse.
REQ-040 Load 3 words then drop load_en -> exactly 3 writes, IDLE, core_rst once, cycle_count=0.
REQ-041 run high 10 cycles then low -> core_en 10 cycles, cycle_count=10, IDLE, no core_rst.
REQ-042 step held high 5 cycles -> one core_en cycle, step_done one cycle later, cycle_count +1.
REQ-043 RUN with core_halted at cycle 4 -> HALT, core_en low; run low -> IDLE with core_rst pulse.
REQ-044 rst_n low mid-LOAD (addr 5) -> outputs at reset values asynchronously; no writes after release.
